// File: rtl/cpu_pkg.sv
// Shared types and constants for the write-back destination tracking pipeline.
// Defines the per-stage record, the bubble value and the hazard FSM states.
package cpu_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int CNT_W      = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rdst;
        logic                  wb;
        logic                  memr;
    } stage_t;

    localparam int     STAGE_W = $bits(stage_t);
    localparam stage_t BUBBLE  = '0;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage record with hold, clear-to-bubble and async reset.
// Hold has priority over clear so a frozen stage keeps its contents.
module pipe_stage_reg
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold_i,
    input  logic               clear_i,
    input  logic [STAGE_W-1:0] d_i,
    output logic [STAGE_W-1:0] q_o
);

    logic [STAGE_W-1:0] stage_q;
    logic [STAGE_W-1:0] stage_d;

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        stage_d = d_i;
        if (hold_i) begin
            stage_d = stage_q;
        end else if (clear_i) begin
            stage_d = BUBBLE;
        end
    end

    // NOTE: state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;

endmodule

// File: rtl/wb_dest_tracker.sv
// Carries destination/write-back/load fields through EX, MEM and WB, detects
// load-use hazards and inserts bubbles, honouring flush and memory-busy freezes.
module wb_dest_tracker
    import cpu_pkg::*;
#(
    parameter int STALL_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Rdst_id,
    input  logic                  WB_id,
    input  logic                  MEMR_id,
    input  logic [REG_ADDR_W-1:0] Rsrc1_id,
    input  logic [REG_ADDR_W-1:0] Rsrc2_id,
    input  logic                  use1_id,
    input  logic                  use2_id,
    input  logic                  flush,
    input  logic                  mem_busy,
    output logic [REG_ADDR_W-1:0] Rdst_ex,
    output logic                  WB_ex,
    output logic                  MEMR_ex,
    output logic [REG_ADDR_W-1:0] Rdst_mem,
    output logic                  WB_mem,
    output logic [REG_ADDR_W-1:0] Rdst_wb,
    output logic                  WB_wb,
    output logic                  stall_id
);

    stage_t             id_rec;
    stage_t             ex_q;
    stage_t             mem_q;
    stage_t             wb_q;
    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               hazard;
    logic               stall_req;
    logic               freeze;

    assign id_rec = '{rdst: Rdst_id, wb: WB_id, memr: MEMR_id};

    // A writing load in EX whose destination feeds an operand actually read in ID.
    assign hazard = ex_q.wb & ex_q.memr &
                    ((use1_id & (Rsrc1_id == ex_q.rdst)) |
                     (use2_id & (Rsrc2_id == ex_q.rdst)));

    assign stall_req = (state_q == STALL) | hazard;
    assign freeze    = mem_busy & ~flush;

    pipe_stage_reg u_ex (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (freeze),
        .clear_i (flush | stall_req),
        .d_i     (id_rec),
        .q_o     (ex_q)
    );

    pipe_stage_reg u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (freeze),
        .clear_i (1'b0),
        .d_i     (ex_q),
        .q_o     (mem_q)
    );

    pipe_stage_reg u_wb (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (1'b0),
        .clear_i (freeze),
        .d_i     (mem_q),
        .q_o     (wb_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!mem_busy) begin
            unique case (state_q)
                IDLE: begin
                    if (hazard) begin
                        cnt_d   = CNT_W'(STALL_CYCLES - 1);
                        state_d = (STALL_CYCLES > 1) ? STALL : IDLE;
                    end
                end
                STALL: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_id = 1'b0;
        if (!flush) begin
            stall_id = mem_busy | stall_req;
        end
    end

    assign Rdst_ex  = ex_q.rdst;
    assign WB_ex    = ex_q.wb;
    assign MEMR_ex  = ex_q.memr;
    assign Rdst_mem = mem_q.rdst;
    assign WB_mem   = mem_q.wb;
    assign Rdst_wb  = wb_q.rdst;
    assign WB_wb    = wb_q.wb;

endmodule

// File: tb/tb_wb_dest_tracker.sv
// Bench for wb_dest_tracker: STALL_CYCLES=1 and =3 instances share one input
// stream; directed steps then random traffic against a queue-style pipeline model.
module tb_wb_dest_tracker;

    typedef struct packed {
        logic [2:0] rdst;
        logic       wb;
        logic       memr;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] Rdst_id, Rsrc1_id, Rsrc2_id;
    logic       WB_id, MEMR_id, use1_id, use2_id, flush, mem_busy;

    logic [2:0] rdst_ex [2];
    logic [2:0] rdst_mem[2];
    logic [2:0] rdst_wb [2];
    logic       wb_ex[2], memr_ex[2], wb_mem[2], wb_wb[2], stall[2];

    int tests = 0;
    int fails = 0;

    rec_t pipe[2][3];
    int   left[2];

    always #5 clk = ~clk;

    wb_dest_tracker #(.STALL_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .Rdst_id(Rdst_id), .WB_id(WB_id), .MEMR_id(MEMR_id),
        .Rsrc1_id(Rsrc1_id), .Rsrc2_id(Rsrc2_id), .use1_id(use1_id), .use2_id(use2_id),
        .flush(flush), .mem_busy(mem_busy),
        .Rdst_ex(rdst_ex[0]), .WB_ex(wb_ex[0]), .MEMR_ex(memr_ex[0]),
        .Rdst_mem(rdst_mem[0]), .WB_mem(wb_mem[0]),
        .Rdst_wb(rdst_wb[0]), .WB_wb(wb_wb[0]), .stall_id(stall[0])
    );

    wb_dest_tracker #(.STALL_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .Rdst_id(Rdst_id), .WB_id(WB_id), .MEMR_id(MEMR_id),
        .Rsrc1_id(Rsrc1_id), .Rsrc2_id(Rsrc2_id), .use1_id(use1_id), .use2_id(use2_id),
        .flush(flush), .mem_busy(mem_busy),
        .Rdst_ex(rdst_ex[1]), .WB_ex(wb_ex[1]), .MEMR_ex(memr_ex[1]),
        .Rdst_mem(rdst_mem[1]), .WB_mem(wb_mem[1]),
        .Rdst_wb(rdst_wb[1]), .WB_wb(wb_wb[1]), .stall_id(stall[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nst(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic m_hazard(input int d);
        rec_t ex;
        ex = pipe[d][0];
        return ex.wb && ex.memr &&
               ((use1_id && (Rsrc1_id == ex.rdst)) || (use2_id && (Rsrc2_id == ex.rdst)));
    endfunction

    function automatic logic m_stall(input int d);
        if (flush)    return 1'b0;
        if (mem_busy) return 1'b1;
        return (left[d] > 0) || m_hazard(d);
    endfunction

    function automatic logic [12:0] m_outs(input int d);
        return {pipe[d][0], pipe[d][1].rdst, pipe[d][1].wb, pipe[d][2].rdst, pipe[d][2].wb};
    endfunction

    function automatic logic [12:0] dut_outs(input int d);
        return {rdst_ex[d], wb_ex[d], memr_ex[d], rdst_mem[d], wb_mem[d], rdst_wb[d], wb_wb[d]};
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 3; s++) pipe[d][s] = '0;
            left[d] = 0;
        end
    endtask

    task automatic m_clock();
        rec_t id;
        logic hz;
        id = '{rdst: Rdst_id, wb: WB_id, memr: MEMR_id};
        for (int d = 0; d < 2; d++) begin
            hz = m_hazard(d);
            if (flush) begin
                pipe[d][2] = pipe[d][1];
                pipe[d][1] = pipe[d][0];
                pipe[d][0] = '0;
                left[d]    = 0;
            end else if (mem_busy) begin
                pipe[d][2] = '0;
            end else if ((left[d] > 0) || hz) begin
                pipe[d][2] = pipe[d][1];
                pipe[d][1] = pipe[d][0];
                pipe[d][0] = '0;
                left[d]    = (left[d] > 0) ? left[d] - 1 : nst(d) - 1;
            end else begin
                pipe[d][2] = pipe[d][1];
                pipe[d][1] = pipe[d][0];
                pipe[d][0] = id;
            end
        end
    endtask

    task automatic set_id(input logic [2:0] rd, input logic wb, input logic mr,
                          input logic [2:0] s1, input logic u1,
                          input logic [2:0] s2, input logic u2);
        Rdst_id = rd; WB_id = wb; MEMR_id = mr;
        Rsrc1_id = s1; use1_id = u1; Rsrc2_id = s2; use2_id = u2;
    endtask

    task automatic idle_in();
        set_id(3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        flush = 1'b0;
        mem_busy = 1'b0;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle(input string tag);
        #1;
        for (int d = 0; d < 2; d++)
            check($sformatf("%s stall[%0d]", tag, d), 32'(stall[d]), 32'(m_stall(d)));
        @(posedge clk);
        m_clock();
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            check($sformatf("%s stages[%0d]", tag, d), 32'(dut_outs(d)), 32'(m_outs(d)));
    endtask

    task automatic idle_cycles(input int n);
        idle_in();
        for (int i = 0; i < n; i++) cycle("idle");
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        m_reset();
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset stages[%0d]", d), 32'(dut_outs(d)), 32'd0);
            check($sformatf("reset stall[%0d]", d), 32'(stall[d]), 32'd0);
        end
        rst_n = 1'b1;

        // Plain advance of two writers and a non-writer.
        set_id(3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); cycle("t1 c1");
        set_id(3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); cycle("t1 c2");
        check("t1 Rdst_mem@2", 32'(rdst_mem[0]), 32'd2);
        check("t1 WB_mem@2", 32'(wb_mem[0]), 32'd1);
        set_id(3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); cycle("t1 c3");
        check("t1 Rdst_wb@3", 32'(rdst_wb[0]), 32'd2);
        check("t1 WB_wb@3", 32'(wb_wb[0]), 32'd1);
        check("t1 Rdst_mem@3", 32'(rdst_mem[0]), 32'd5);
        idle_cycles(3);

        // Load R1 followed by a use of R1 on operand 2.
        set_id(3'd1, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0); cycle("t2 load");
        set_id(3'd4, 1'b1, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1);
        #1 check("t2 stall comb", 32'(stall[0]), 32'd1);
        cycle("t2 stall");
        check("t2 EX bubble", 32'({rdst_ex[0], wb_ex[0], memr_ex[0]}), 32'd0);
        check("t2 load in MEM", 32'({rdst_mem[0], wb_mem[0]}), 32'({3'd1, 1'b1}));
        #1 check("t2 stall released", 32'(stall[0]), 32'd0);
        cycle("t2 issue");
        check("t2 dep in EX", 32'({rdst_ex[0], wb_ex[0]}), 32'({3'd4, 1'b1}));
        idle_cycles(4);

        // Matching source that is not read; load that does not write.
        set_id(3'd1, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0); cycle("t3 load");
        set_id(3'd6, 1'b1, 1'b0, 3'd1, 1'b0, 3'd1, 1'b0);
        #1 check("t3 unused src", 32'(stall[0]), 32'd0);
        cycle("t3 nouse");
        set_id(3'd1, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0); cycle("t3 nwload");
        set_id(3'd6, 1'b1, 1'b0, 3'd1, 1'b1, 3'd0, 1'b0);
        #1 check("t3 non-writing load", 32'(stall[0]), 32'd0);
        cycle("t3 nwuse");
        idle_cycles(4);

        // Three-cycle stall on the STALL_CYCLES=3 build.
        set_id(3'd6, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0); cycle("t4 load");
        set_id(3'd7, 1'b1, 1'b0, 3'd6, 1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("t4 stall %0d", i), 32'(stall[1]), 32'd1);
            cycle("t4 stall");
            check($sformatf("t4 bubble %0d", i), 32'({rdst_ex[1], wb_ex[1], memr_ex[1]}), 32'd0);
        end
        #1 check("t4 release", 32'(stall[1]), 32'd0);
        cycle("t4 issue");
        check("t4 dep in EX", 32'({rdst_ex[1], wb_ex[1]}), 32'({3'd7, 1'b1}));
        idle_cycles(4);

        // Memory-busy freeze with R3 in MEM.
        set_id(3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); cycle("t5 r3");
        idle_in(); cycle("t5 adv");
        mem_busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1 check($sformatf("t5 busy stall %0d", i), 32'(stall[0]), 32'd1);
            cycle("t5 busy");
            check($sformatf("t5 Rdst_mem held %0d", i), 32'({rdst_mem[0], wb_mem[0]}), 32'({3'd3, 1'b1}));
            check($sformatf("t5 WB_wb low %0d", i), 32'(wb_wb[0]), 32'd0);
        end
        mem_busy = 1'b0;
        cycle("t5 resume");
        check("t5 R3 to WB", 32'({rdst_wb[0], wb_wb[0]}), 32'({3'd3, 1'b1}));
        idle_cycles(4);

        // Flush in the second stall cycle of the STALL_CYCLES=3 build.
        set_id(3'd2, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0); cycle("t6 load");
        set_id(3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1); cycle("t6 stall1");
        flush = 1'b1;
        #1 check("t6 flush drops stall", 32'(stall[1]), 32'd0);
        cycle("t6 flush");
        check("t6 flush EX bubble", 32'({rdst_ex[1], wb_ex[1], memr_ex[1]}), 32'd0);
        flush = 1'b0;
        idle_cycles(4);

        // Reset asserted in the middle of a stall.
        set_id(3'd2, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0); cycle("t6 load2");
        set_id(3'd5, 1'b1, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0); cycle("t6 stall2");
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("t6 midrst stages[%0d]", d), 32'(dut_outs(d)), 32'd0);
            check($sformatf("t6 midrst stall[%0d]", d), 32'(stall[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // Random traffic on a small register window to provoke frequent hazards.
        for (int i = 0; i < 400; i++) begin
            set_id(3'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            flush    = ($urandom_range(0, 19) == 0);
            mem_busy = ($urandom_range(0, 7) == 0);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
